// File: rtl/entry_wise_mean.sv
// entry_wise_mean: five-lane iterative divide-by-5 producing saturated
// 12-bit floor(e_i / 5). Free-running 18-cycle frame:
// LOAD (capture) -> DIV (16 restoring shift-subtract steps) -> DONE (publish).
module entry_wise_mean (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] e1,
  input  logic [15:0] e2,
  input  logic [15:0] e3,
  input  logic [15:0] e4,
  input  logic [15:0] e5,
  output logic [11:0] mean_e1,
  output logic [11:0] mean_e2,
  output logic [11:0] mean_e3,
  output logic [11:0] mean_e4,
  output logic [11:0] mean_e5,
  output logic        ready
);

  typedef enum logic [1:0] {LOAD, DIV, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [15:0] e_in [5];
  logic [15:0] dvd  [5];
  logic [3:0]  rem  [5];
  logic [15:0] quo  [5];
  logic [11:0] mean [5];

  assign e_in[0] = e1;
  assign e_in[1] = e2;
  assign e_in[2] = e3;
  assign e_in[3] = e4;
  assign e_in[4] = e5;

  assign mean_e1 = mean[0];
  assign mean_e2 = mean[1];
  assign mean_e3 = mean[2];
  assign mean_e4 = mean[3];
  assign mean_e5 = mean[4];

  // One restoring step: shift in the next dividend bit, subtract 5 if it fits.
  // Returns {quotient_bit, new_remainder}. r[3] is never set because the
  // remainder stays below 5; folding it into the compare keeps the step total.
  function automatic logic [4:0] div_step(input logic [3:0] r, input logic b);
    logic [3:0] t;
    t = {r[2:0], b};
    if (r[3] || (t >= 4'd5))
      return {1'b1, t - 4'd5};
    else
      return {1'b0, t};
  endfunction

  // Clamp the 16-bit quotient into the 12-bit pixel range.
  function automatic logic [11:0] sat12(input logic [15:0] q);
    return (q >= 16'd4096) ? 12'hFFF : q[11:0];
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state logic: LOAD -> DIV (16 cycles) -> DONE -> LOAD.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    state_nxt = DIV;
      DIV:     if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Datapath: capture, iterate MSB-first (quotient shifts in from the LSB), publish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= 4'd0;
      ready <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        dvd[i]  <= '0;
        rem[i]  <= '0;
        quo[i]  <= '0;
        mean[i] <= '0;
      end
    end else begin
      ready <= (state == DONE);
      case (state)
        LOAD: begin
          cnt <= 4'd15;
          for (int i = 0; i < 5; i++) begin
            dvd[i] <= e_in[i];
            rem[i] <= '0;
            quo[i] <= '0;
          end
        end
        DIV: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          for (int i = 0; i < 5; i++)
            {quo[i], rem[i]} <= {quo[i][14:0], div_step(rem[i], dvd[i][cnt])};
        end
        DONE: begin
          for (int i = 0; i < 5; i++)
            mean[i] <= sat12(quo[i]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_entry_wise_mean.sv
// Scoreboard bench for entry_wise_mean: stimulus pushes expected results with
// their due cycle; a negedge monitor pops and compares on every ready pulse.
module tb_entry_wise_mean;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] e1 = '0, e2 = '0, e3 = '0, e4 = '0, e5 = '0;
  logic [11:0] mean_e1, mean_e2, mean_e3, mean_e4, mean_e5;
  logic        ready;

  entry_wise_mean dut (
    .clk(clk), .rst(rst),
    .e1(e1), .e2(e2), .e3(e3), .e4(e4), .e5(e5),
    .mean_e1(mean_e1), .mean_e2(mean_e2), .mean_e3(mean_e3),
    .mean_e4(mean_e4), .mean_e5(mean_e5),
    .ready(ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [11:0] act [5];
  assign act[0] = mean_e1;
  assign act[1] = mean_e2;
  assign act[2] = mean_e3;
  assign act[3] = mean_e4;
  assign act[4] = mean_e5;

  typedef struct {
    logic [4:0][11:0] m;
    int               due;
  } exp_t;

  exp_t        sb [$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] cur_e [5];
  logic [11:0] cur_x [5];
  logic [15:0] tv [7][5];
  logic [11:0] tx [7][5];

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_ready"}, int'(ready), 0);
    for (int i = 0; i < 5; i++)
      chk($sformatf("%s_mean_e%0d", name, i + 1), int'(act[i]), 0);
  endtask

  task automatic load(input int k);
    for (int i = 0; i < 5; i++) begin
      cur_e[i] = tv[k][i];
      cur_x[i] = tx[k][i];
    end
  endtask

  // Drive cur_e ahead of the coming LOAD edge and record the expected result,
  // which appears after the DONE edge, 18 rising edges from now.
  task automatic issue();
    exp_t t;
    #1;
    e1 = cur_e[0]; e2 = cur_e[1]; e3 = cur_e[2]; e4 = cur_e[3]; e5 = cur_e[4];
    for (int i = 0; i < 5; i++) t.m[i] = cur_x[i];
    t.due = cyc + 18;
    sb.push_back(t);
  endtask

  task automatic wait_period();
    repeat (18) @(posedge clk);
  endtask

  exp_t mon_t;
  logic prev_rdy = 1'b0;

  // Monitor: every ready pulse must match the oldest pending expectation,
  // arrive on its due cycle, and never follow another ready directly.
  always @(negedge clk) begin
    if (rst) begin
      prev_rdy = 1'b0;
    end else begin
      if (ready) begin
        chk("ready_back_to_back", int'(prev_rdy), 0);
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ready: got ready=1 expected no pending result (cycle %0d)", cyc);
        end else begin
          mon_t = sb.pop_front();
          chk("ready_latency", cyc, mon_t.due);
          for (int i = 0; i < 5; i++)
            chk($sformatf("mean_e%0d", i + 1), int'(act[i]), int'(mon_t.m[i]));
        end
      end
      prev_rdy = ready;
    end
  end

  initial begin
    tv = '{'{16'd4095,  16'd20475, 16'd4520,  16'd7568, 16'd4832},
           '{16'd9685,  16'd9606,  16'd15986, 16'd0,    16'd2345},
           '{16'd20479, 16'd20480, 16'd65535, 16'd4,    16'd5},
           '{16'd65534, 16'd20484, 16'd20474, 16'd10,   16'd14},
           '{16'd1,     16'd2,     16'd3,     16'd9,    16'd40000},
           '{16'd100,   16'd999,   16'd12345, 16'd6,    16'd20485},
           '{16'd7,     16'd8,     16'd3000,  16'd500,  16'd1}};
    tx = '{'{12'd819,  12'd4095, 12'd904,  12'd1513, 12'd966},
           '{12'd1937, 12'd1921, 12'd3197, 12'd0,    12'd469},
           '{12'd4095, 12'd4095, 12'd4095, 12'd0,    12'd1},
           '{12'd4095, 12'd4095, 12'd4094, 12'd2,    12'd2},
           '{12'd0,    12'd0,    12'd0,    12'd1,    12'd4095},
           '{12'd20,   12'd199,  12'd2469, 12'd1,    12'd4095},
           '{12'd1,    12'd1,    12'd600,  12'd100,  12'd0}};

    // Reset held while the clock runs.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("rst_hold");
    rst = 1'b0;

    // Directed sets back to back, one per 18-cycle frame.
    for (int k = 0; k < 4; k++) begin
      load(k);
      issue();
      wait_period();
    end

    // Inputs change 5 cycles into the frame: current result keeps the old set.
    load(4);
    issue();
    repeat (6) @(posedge clk);
    #1;
    e1 = tv[5][0]; e2 = tv[5][1]; e3 = tv[5][2]; e4 = tv[5][3]; e5 = tv[5][4];
    repeat (12) @(posedge clk);
    load(5);
    issue();
    wait_period();

    // Asynchronous reset mid-DIV discards the in-flight set.
    load(6);
    issue();
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("rst_async");
    sb.delete();
    @(negedge clk);
    chk_zero("rst_mid");
    rst = 1'b0;
    load(1);
    issue();
    wait_period();

    // A handful of arbitrary vectors against the floor/saturate model.
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 5; i++) begin
        int v;
        v = int'($urandom_range(0, 65535));
        cur_e[i] = v[15:0];
        cur_x[i] = ((v / 5) > 4095) ? 12'd4095 : 12'(v / 5);
      end
      issue();
      wait_period();
    end

    // Drain the last pending result within a bounded window.
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
